bm_rng_ustream: RTL

- Parametrised uniform-source front end for the next-generation Box-Muller Gaussian generator.
- Contains NUM_CH independent 32-bit three-component Tausworthe (taus88) generators.
  - Each generator is software-seedable.
  - Each has a WARMUP discard phase.
- All channels advance in lockstep. Their combined words are buffered in a FIFO.
- Output uses a ready/valid handshake, so the downstream log/sqrt/sin-cos pipeline can stall it.

---
 rtl/bm_rng_ustream.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/bm_rng_ustream.sv
// bm_rng_ustream: NUM_CH lockstep taus88 uniform generators with software seeding,
// a WARMUP discard phase and a ready/valid output FIFO feeding the Box-Muller pipeline.
// Optional statistics outputs (sample_cnt, stall_cnt) exist only when the macro
// BM_RNG_USTREAM_STATS_EN is defined; the default build omits them entirely.
module bm_rng_ustream #(
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int WARMUP     = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          seed_we,
    input  logic [2:0]                    seed_ch,
    input  logic [1:0]                    seed_idx,
    input  logic [31:0]                   seed_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_CH*32-1:0]          out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [1:0]                    state_o,
    output logic                          seed_err
`ifdef BM_RNG_USTREAM_STATS_EN
    ,
    output logic [31:0]                   sample_cnt,
    output logic [15:0]                   stall_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = NUM_CH * 32;
    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
    // Index of the last warm-up step; unused when WARMUP is 0 (IDLE goes straight to RUN)
    localparam logic [7:0]    WARM_LAST  = (WARMUP > 0) ? 8'(WARMUP - 1) : 8'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WARM = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // taus88 component recurrences, all arithmetic kept at 32 bits like the C reference
    function automatic logic [31:0] taus_s1(input logic [31:0] s);
        logic [31:0] t;
        logic [31:0] m;
        t = ((s << 13) ^ s) >> 19;
        m = s & 32'hFFFF_FFFE;
        return (m << 12) ^ t;
    endfunction

    function automatic logic [31:0] taus_s2(input logic [31:0] s);
        logic [31:0] t;
        logic [31:0] m;
        t = ((s << 2) ^ s) >> 25;
        m = s & 32'hFFFF_FFF8;
        return (m << 4) ^ t;
    endfunction

    function automatic logic [31:0] taus_s3(input logic [31:0] s);
        logic [31:0] t;
        logic [31:0] m;
        t = ((s << 3) ^ s) >> 11;
        m = s & 32'hFFFF_FFF0;
        return (m << 17) ^ t;
    endfunction

    state_t           state_q, state_d;
    logic [7:0]       warm_cnt_q, warm_cnt_d;
    logic             step;
    logic             push;
    logic             pop;
    logic             full;
    logic             seed_ok;
    logic             seed_err_q, seed_err_d;
    logic [DW-1:0]    gen_word;
    logic [DW-1:0]    head_q, head_d;
    logic [DW-1:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [LW-1:0]    level_q, level_d;

    assign full       = (level_q == LEVEL_FULL);
    assign out_valid  = (level_q != '0);
    assign pop        = out_valid && out_ready;
    assign out_data   = head_q;
    assign fifo_level = level_q;
    assign state_o    = state_q;
    assign seed_err   = seed_err_q;
    assign rd_ptr_nxt = rd_ptr_q + 1'b1;

    // A seed write is legal only in IDLE with enable low, on an existing channel and component
    assign seed_ok = seed_we && (state_q == ST_IDLE) && !enable
                     && (int'(seed_ch) < NUM_CH) && (seed_idx != 2'd3);

    // Per-channel generator state: seed load, step or hold
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [31:0] s1_q, s2_q, s3_q;
        logic [31:0] s1_d, s2_d, s3_d;
        logic [31:0] s1_n, s2_n, s3_n;
        logic        ld_ch;

        assign ld_ch = seed_ok && (seed_ch == 3'(gi));
        assign s1_n  = taus_s1(s1_q);
        assign s2_n  = taus_s2(s2_q);
        assign s3_n  = taus_s3(s3_q);
        assign gen_word[gi*32 +: 32] = s1_n ^ s2_n ^ s3_n;

        // Seed loads force the low bits that keep each component out of its degenerate states
        always_comb begin
            s1_d = s1_q;
            s2_d = s2_q;
            s3_d = s3_q;
            if (ld_ch) begin
                case (seed_idx)
                    2'd0:    s1_d = seed_data | 32'h0000_0002;
                    2'd1:    s2_d = seed_data | 32'h0000_0008;
                    default: s3_d = seed_data | 32'h0000_0010;
                endcase
            end else if (step) begin
                s1_d = s1_n;
                s2_d = s2_n;
                s3_d = s3_n;
            end
        end

        // Seed registers, reset to channel-specific default seeds
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1_q <= 32'h0000_1234 + 32'(gi);
                s2_q <= 32'h0000_5678 + 32'(gi);
                s3_q <= 32'h0009_ABCD + 32'(gi);
            end else begin
                s1_q <= s1_d;
                s2_q <= s2_d;
                s3_q <= s3_d;
            end
        end
    end

    // Sequencer: decides when generators step and when a new entry is pushed
    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        step       = 1'b0;
        push       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    warm_cnt_d = '0;
                    state_d    = (WARMUP > 0) ? ST_WARM : ST_RUN;
                end
            end
            ST_WARM: begin
                // Dropping enable abandons the warm-up without stepping
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    step = 1'b1;
                    if (warm_cnt_q == WARM_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        warm_cnt_d = warm_cnt_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // enable low stops pushing immediately; draining continues from IDLE
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (!full || pop) begin
                    push = 1'b1;
                    step = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next FIFO head: keep out_data registered and stable unless the head entry changes
    always_comb begin
        head_d = head_q;
        if (pop) begin
            if (level_q == LEVEL_ONE) begin
                if (push) begin
                    head_d = gen_word;
                end
            end else begin
                head_d = mem_q[rd_ptr_nxt];
            end
        end else if ((level_q == '0) && push) begin
            head_d = gen_word;
        end
    end

    // Pointer and occupancy bookkeeping
    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_nxt : rd_ptr_q;
        level_d    = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (!push && pop) begin
            level_d = level_q - 1'b1;
        end
        seed_err_d = seed_err_q | (seed_we & ~seed_ok);
    end

    // Entry storage; validity is tracked by level_q so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= gen_word;
        end
    end

    // Control and FIFO state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            warm_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            head_q     <= '0;
            seed_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            head_q     <= head_d;
            seed_err_q <= seed_err_d;
        end
    end

`ifdef BM_RNG_USTREAM_STATS_EN
    logic [31:0] sample_cnt_q, sample_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating pop and back-pressure counters
    always_comb begin
        sample_cnt_d = sample_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (pop && (sample_cnt_q != '1)) begin
            sample_cnt_d = sample_cnt_q + 1'b1;
        end
        if ((state_q == ST_RUN) && full && !pop && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign sample_cnt = sample_cnt_q;
    assign stall_cnt  = stall_cnt_q;
`endif

endmodule
